// File: rtl/vga_timing_pkg.sv
// Default VGA timing shared by the display transmitter and the receive monitor,
// plus the monitor's lock-state encoding.
package vga_timing_pkg;

  localparam int unsigned CLKS_PER_PIXEL = 4;
  localparam int unsigned H_TOTAL        = 800;
  localparam int unsigned V_TOTAL        = 525;
  localparam int unsigned H_VISIBLE      = 640;
  localparam int unsigned V_VISIBLE      = 480;
  localparam int unsigned H_OFFSET       = 144;
  localparam int unsigned V_OFFSET       = 35;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } rx_state_t;

endpackage

// File: rtl/sync_fall_detect.sv
// Two-flop synchronizer with a falling-edge pulse derived from the synchronized level.
module sync_fall_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_sync_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_meta   <= i_async;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
    end
  end

  assign o_fall = r_sync_d & ~r_sync;

endmodule

// File: rtl/vga_rx_monitor.sv
// VGA receive monitor: locks to HS/VS timing, recovers pixel coordinates and colour,
// flags line/frame length errors and produces a per-frame 16-bit colour checksum.
module vga_rx_monitor
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLKS_PER_PIXEL = vga_timing_pkg::CLKS_PER_PIXEL,
  parameter int unsigned H_TOTAL        = vga_timing_pkg::H_TOTAL,
  parameter int unsigned V_TOTAL        = vga_timing_pkg::V_TOTAL,
  parameter int unsigned H_VISIBLE      = vga_timing_pkg::H_VISIBLE,
  parameter int unsigned V_VISIBLE      = vga_timing_pkg::V_VISIBLE,
  parameter int unsigned H_OFFSET       = vga_timing_pkg::H_OFFSET,
  parameter int unsigned V_OFFSET       = vga_timing_pkg::V_OFFSET
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        HS,
  input  logic        VS,
  input  logic [2:0]  R,
  input  logic [2:0]  G,
  input  logic [1:0]  B,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [7:0]  pix_rgb,
  output logic        locked,
  output logic        err_line,
  output logic        err_frame,
  output logic        frame_done,
  output logic [15:0] frame_sum
);

  localparam int unsigned PIX_SHIFT   = $clog2(CLKS_PER_PIXEL);
  localparam logic [13:0] CNT_MAX     = '1;
  localparam logic [13:0] LINE_LEN_M1 = 14'(H_TOTAL * CLKS_PER_PIXEL - 1);
  localparam logic [13:0] PHASE_MASK  = 14'(CLKS_PER_PIXEL - 1);
  localparam logic [13:0] TICK_PHASE  = 14'(CLKS_PER_PIXEL / 2);
  localparam logic [13:0] HX_LO       = 14'(H_OFFSET);
  localparam logic [13:0] HX_HI       = 14'(H_OFFSET + H_VISIBLE);
  localparam logic [10:0] VY_LO       = 11'(V_OFFSET);
  localparam logic [10:0] VY_HI       = 11'(V_OFFSET + V_VISIBLE);
  localparam logic [11:0] V_TOT       = 12'(V_TOTAL);

  rx_state_t   r_state, w_state_next;
  logic        w_hs_fall, w_vs_fall;
  logic [7:0]  r_rgb_meta, r_rgb_s;
  logic [13:0] r_clk_cnt, w_clk_cnt, w_pix_idx, w_phase;
  logic [10:0] r_line_cnt, w_line_cnt;
  logic        r_skip, r_acq_bad;
  logic        w_active, w_line_bad, w_frame_ok;
  logic        w_lock_enter, w_frame_commit, w_err_line_set, w_err_frame_set, w_sample;
  logic [15:0] r_acc, w_acc_next;

  sync_fall_detect u_hs_sync (.i_clk(clk), .i_rst_n(rst), .i_async(HS), .o_fall(w_hs_fall));
  sync_fall_detect u_vs_sync (.i_clk(clk), .i_rst_n(rst), .i_async(VS), .o_fall(w_vs_fall));

  // Counters are defined for the current cycle; the registers hold the previous
  // cycle's value, which is the pre-reset value the line check needs.
  assign w_clk_cnt  = w_hs_fall ? '0 :
                      (r_clk_cnt == CNT_MAX) ? r_clk_cnt : r_clk_cnt + 14'd1;
  assign w_line_cnt = w_vs_fall ? '0 :
                      (w_hs_fall && (r_line_cnt != '1)) ? r_line_cnt + 11'd1 : r_line_cnt;
  assign w_pix_idx  = w_clk_cnt >> PIX_SHIFT;
  assign w_phase    = w_clk_cnt & PHASE_MASK;
  assign w_active   = (w_phase == TICK_PHASE) &&
                      (w_pix_idx >= HX_LO) && (w_pix_idx < HX_HI) &&
                      (w_line_cnt >= VY_LO) && (w_line_cnt < VY_HI);
  assign w_line_bad = w_hs_fall && !r_skip && (r_clk_cnt != LINE_LEN_M1);
  assign w_frame_ok = (({1'b0, r_line_cnt} + {11'd0, w_hs_fall}) == V_TOT);
  assign w_acc_next = r_acc + (pix_valid ? {8'd0, pix_rgb} : 16'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_vs_fall) w_state_next = ACQUIRE;
      ACQUIRE: if (w_vs_fall && !r_acq_bad && !w_line_bad && w_frame_ok) w_state_next = LOCKED;
      LOCKED:  if (w_line_bad || (w_vs_fall && !w_frame_ok)) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    locked          = (r_state == LOCKED);
    w_lock_enter    = (r_state == ACQUIRE) && (w_state_next == LOCKED);
    w_err_line_set  = (r_state == LOCKED) && w_line_bad;
    w_err_frame_set = (r_state == LOCKED) && w_vs_fall && !w_frame_ok;
    w_frame_commit  = (r_state == LOCKED) && w_vs_fall && w_frame_ok && !w_line_bad;
    w_sample        = (r_state == LOCKED) && w_active;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rgb_meta <= '0;
      r_rgb_s    <= '0;
      r_clk_cnt  <= '0;
      r_line_cnt <= '0;
      r_skip     <= 1'b1;
      r_acq_bad  <= 1'b0;
      r_acc      <= '0;
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_rgb    <= '0;
      err_line   <= 1'b0;
      err_frame  <= 1'b0;
      frame_done <= 1'b0;
      frame_sum  <= '0;
    end else begin
      r_rgb_meta <= {R, G, B};
      r_rgb_s    <= r_rgb_meta;
      r_clk_cnt  <= w_clk_cnt;
      r_line_cnt <= w_line_cnt;
      if (r_state == IDLE) r_skip <= 1'b1;
      else if (w_hs_fall)  r_skip <= 1'b0;
      if ((r_state != ACQUIRE) || w_vs_fall) r_acq_bad <= 1'b0;
      else if (w_line_bad)                   r_acq_bad <= 1'b1;
      pix_valid <= w_sample;
      if (w_sample) begin
        pix_x   <= 10'(w_pix_idx - HX_LO);
        pix_y   <= 10'(w_line_cnt - VY_LO);
        pix_rgb <= r_rgb_s;
      end
      err_line   <= w_err_line_set;
      err_frame  <= w_err_frame_set;
      frame_done <= w_frame_commit;
      if (w_frame_commit) frame_sum <= w_acc_next;
      r_acc <= (w_lock_enter || w_frame_commit) ? '0 : w_acc_next;
    end
  end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Bench for vga_rx_monitor on a reduced timing grid: per-frame table of scenarios
// and a pixel scoreboard filled by the stream generator.
module tb_vga_rx_monitor;

  localparam int CPP  = 2;
  localparam int HT   = 36;
  localparam int VT   = 12;
  localparam int HV   = 24;
  localparam int VV   = 6;
  localparam int HO   = 6;
  localparam int VO   = 3;
  localparam int HS_W = 3;
  localparam int VS_W = 2;
  localparam int NROW = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        HS, VS;
  logic [2:0]  R, G;
  logic [1:0]  B;
  logic        pix_valid, locked, err_line, err_frame, frame_done;
  logic [9:0]  pix_x, pix_y;
  logic [7:0]  pix_rgb;
  logic [15:0] frame_sum;

  vga_rx_monitor #(
    .CLKS_PER_PIXEL(CPP), .H_TOTAL(HT), .V_TOTAL(VT), .H_VISIBLE(HV),
    .V_VISIBLE(VV), .H_OFFSET(HO), .V_OFFSET(VO)
  ) dut (
    .clk(clk), .rst(rst), .HS(HS), .VS(VS), .R(R), .G(G), .B(B),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .locked(locked), .err_line(err_line), .err_frame(err_frame),
    .frame_done(frame_done), .frame_sum(frame_sum)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [7:0]  rgb;
    int unsigned t;
  } exp_t;

  // mode 0: constant 0xE3, mode 1: coordinate pattern
  typedef struct {
    int mode;
    int nlines;
    int long_line;
    int rst_line;
    bit exp_px;
    int exp_done;
    int exp_el;
    int exp_ef;
    bit exp_lock;
  } row_t;

  exp_t        sb[$];
  exp_t        mon_e;
  row_t        rows[NROW];
  int          total = 0;
  int          bad   = 0;
  int          n_pv, n_done, n_el, n_ef, pushed;
  logic [15:0] last_sum, cur_sum, prev_sum;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (pix_valid) begin
        n_pv++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_underflow: unexpected pixel x=%0d y=%0d rgb=%0d", pix_x, pix_y, pix_rgb);
        end else begin
          mon_e = sb.pop_front();
          chk("pix_x", longint'(pix_x), longint'(mon_e.x));
          chk("pix_y", longint'(pix_y), longint'(mon_e.y));
          chk("pix_rgb", longint'(pix_rgb), longint'(mon_e.rgb));
          chk("latency", longint'(cyc - mon_e.t), 3);
        end
      end
      if (frame_done) begin
        n_done++;
        last_sum = frame_sum;
      end
      if (err_line)  n_el++;
      if (err_frame) n_ef++;
    end
  end

  task automatic gen_frame(input row_t r);
    int         plen, k;
    bit         vis;
    logic [9:0] x, y;
    logic [7:0] rgb;
    for (int ln = 0; ln < r.nlines; ln++) begin
      plen = (ln == r.long_line) ? HT + 1 : HT;
      for (int px = 0; px < plen; px++) begin
        for (int sub = 0; sub < CPP; sub++) begin
          @(negedge clk);
          k = px * CPP + sub;
          if (ln == r.rst_line && k == 0) begin
            rst = 1'b0;
            #1;
            chk("rst_async_outputs",
                longint'({pix_valid, pix_x, pix_y, pix_rgb, locked, err_line,
                          err_frame, frame_done, frame_sum}), 0);
          end
          if (ln == r.rst_line && k == 2) rst = 1'b1;
          HS  = (px >= HS_W);
          VS  = (ln >= VS_W);
          vis = (px >= HO) && (px < HO + HV) && (ln >= VO) && (ln < VO + VV);
          x   = 10'(px - HO);
          y   = 10'(ln - VO);
          rgb = !vis ? 8'h00 : (r.mode != 0) ? {x[2:0], y[2:0], x[4:3]} : 8'hE3;
          {R, G, B} = rgb;
          if (vis && sub == CPP / 2 && r.exp_px &&
              (r.long_line < 0 || ln <= r.long_line) &&
              (r.rst_line < 0 || ln < r.rst_line)) begin
            sb.push_back('{x: x, y: y, rgb: rgb, t: cyc});
            cur_sum = cur_sum + {8'd0, rgb};
            pushed++;
          end
        end
      end
    end
  endtask

  initial begin
    //          mode lines long rst  px done el ef lock
    rows[0]  = '{0, 12, -1, -1, 0, 0, 0, 0, 0};
    rows[1]  = '{0, 12, -1, -1, 1, 0, 0, 0, 1};
    rows[2]  = '{1, 12, -1, -1, 1, 1, 0, 0, 1};
    rows[3]  = '{1, 12,  5, -1, 1, 1, 1, 0, 0};
    rows[4]  = '{1, 12, -1, -1, 0, 0, 0, 0, 0};
    rows[5]  = '{1, 12, -1, -1, 1, 0, 0, 0, 1};
    rows[6]  = '{1, 11, -1, -1, 1, 1, 0, 0, 1};
    rows[7]  = '{1, 12, -1, -1, 0, 0, 0, 1, 0};
    rows[8]  = '{1, 12, -1, -1, 0, 0, 0, 0, 0};
    rows[9]  = '{1, 12, -1, -1, 1, 0, 0, 0, 1};
    rows[10] = '{1, 12, -1, -1, 1, 1, 0, 0, 1};
    rows[11] = '{1, 12, -1,  4, 1, 1, 0, 0, 0};
    rows[12] = '{0, 12, -1, -1, 0, 0, 0, 0, 0};
    rows[13] = '{0, 12, -1, -1, 1, 0, 0, 0, 1};
    rows[14] = '{0, 12, -1, -1, 1, 1, 0, 0, 1};
    rows[15] = '{0, 12, -1, -1, 1, 1, 0, 0, 1};

    rst = 1'b0;
    HS = 1'b1; VS = 1'b1; R = '0; G = '0; B = '0;
    cur_sum = '0; prev_sum = '0; last_sum = '0;
    repeat (3) @(negedge clk);
    chk("reset_state",
        longint'({pix_valid, pix_x, pix_y, pix_rgb, locked, err_line,
                  err_frame, frame_done, frame_sum}), 0);
    rst = 1'b1;
    repeat (10) @(negedge clk);

    for (int i = 0; i < NROW; i++) begin
      prev_sum = cur_sum;
      cur_sum  = '0;
      pushed   = 0;
      n_pv = 0; n_done = 0; n_el = 0; n_ef = 0;
      gen_frame(rows[i]);
      chk($sformatf("row%0d_pix_count", i), n_pv, pushed);
      chk($sformatf("row%0d_sb_left", i), sb.size(), 0);
      chk($sformatf("row%0d_frame_done", i), n_done, rows[i].exp_done);
      chk($sformatf("row%0d_err_line", i), n_el, rows[i].exp_el);
      chk($sformatf("row%0d_err_frame", i), n_ef, rows[i].exp_ef);
      chk($sformatf("row%0d_locked", i), longint'(locked), longint'(rows[i].exp_lock));
      if (rows[i].exp_done != 0)
        chk($sformatf("row%0d_frame_sum", i), longint'(last_sum), longint'(prev_sum));
      sb.delete();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
